// File: rtl/disaster_pkg.sv
// Shared definitions for the disaster-detector front end.
// Holds channel indices, the 2-bit level type and the encoder FSM states.
package disaster_pkg;

  localparam logic [1:0] CH_RAIN  = 2'd0;
  localparam logic [1:0] CH_SEIS  = 2'd1;
  localparam logic [1:0] CH_WIND  = 2'd2;
  localparam logic [1:0] CH_LEVEL = 2'd3;

  typedef logic [1:0] level_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_QUANT   = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

endpackage

// File: rtl/level_quantizer.sv
// Combinational 0..3 level quantizer with falling hysteresis.
// Rising edges use TH1..TH3 directly; falling edges use TH-HYST clamped at zero.
module level_quantizer
  import disaster_pkg::*;
#(
  parameter int TH1  = 64,
  parameter int TH2  = 128,
  parameter int TH3  = 192,
  parameter int HYST = 8
) (
  input  logic [7:0] avg,
  input  level_t     level_cur,
  output level_t     level_new
);

  localparam int DN1 = (TH1 > HYST) ? TH1 - HYST : 0;
  localparam int DN2 = (TH2 > HYST) ? TH2 - HYST : 0;
  localparam int DN3 = (TH3 > HYST) ? TH3 - HYST : 0;

  logic [31:0] avg_w;
  level_t      up;
  level_t      down;
  level_t      held;

  assign avg_w = 32'(avg);

  // A level is kept while avg stays above the lowered thresholds, never below the rising count.
  always_comb begin
    up   = 2'(avg_w >= 32'(TH1)) + 2'(avg_w >= 32'(TH2)) + 2'(avg_w >= 32'(TH3));
    down = 2'(avg_w >= 32'(DN1)) + 2'(avg_w >= 32'(DN2)) + 2'(avg_w >= 32'(DN3));
    held = (level_cur < down) ? level_cur : down;
    level_new = (up > held) ? up : held;
  end

endmodule

// File: rtl/sensor_level_encoder.sv
// Scans rain/seismic/wind/water-level over req/ack, averages and quantizes each to 0..3.
// Optional ack watchdog with per-channel fault flags: define SENSOR_TIMEOUT_EN.
module sensor_level_encoder
  import disaster_pkg::*;
#(
  parameter int AVG_LOG2    = 2,
  parameter int TH1         = 64,
  parameter int TH2         = 128,
  parameter int TH3         = 192,
  parameter int HYST        = 8
`ifdef SENSOR_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       adc_req,
  output logic [1:0] adc_sel,
  input  logic       adc_ack,
  input  logic [7:0] adc_data,
  output logic       r1,
  output logic       r0,
  output logic       s1,
  output logic       s0,
  output logic       w1,
  output logic       w0,
  output logic       l1,
  output logic       l0,
  output logic       levels_valid,
  output logic       scan_busy,
  output logic [3:0] sensor_fault
);

  localparam int NSAMP = 1 << AVG_LOG2;
  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  state_t           state;
  state_t           state_next;
  logic [1:0]       ch;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  level_t [3:0]     lvl;
  level_t           lvl_new;
  logic [7:0]       avg;
  logic [7:0]       pub;
  logic             capture;
  logic             last_capture;
  logic             timeout;
  logic             skip;

  assign capture      = (state == ST_SAMPLE) && adc_ack;
  assign last_capture = capture && (cnt == CNT_W'(NSAMP - 1));
  assign avg          = 8'(acc >> AVG_LOG2);

  assign adc_req      = (state == ST_SAMPLE);
  assign adc_sel      = ch;
  assign levels_valid = (state == ST_PUBLISH);
  assign scan_busy    = (state != ST_IDLE);
  assign {r1, r0, s1, s0, w1, w0, l1, l0} = pub;

  level_quantizer #(
    .TH1  (TH1),
    .TH2  (TH2),
    .TH3  (TH3),
    .HYST (HYST)
  ) u_quant (
    .avg       (avg),
    .level_cur (lvl[ch]),
    .level_new (lvl_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (enable) state_next = ST_SAMPLE;
      ST_SAMPLE:  if (last_capture || timeout) state_next = ST_QUANT;
      ST_QUANT:   state_next = (ch == CH_LEVEL) ? ST_PUBLISH : ST_SAMPLE;
      ST_PUBLISH: state_next = enable ? ST_SAMPLE : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Published levels load on entry to PUBLISH so they appear alongside levels_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch  <= CH_RAIN;
      cnt <= '0;
      acc <= '0;
      lvl <= '0;
      pub <= '0;
    end else begin
      case (state)
        ST_IDLE: ch <= CH_RAIN;
        ST_SAMPLE: begin
          if (capture) begin
            acc <= acc + ACC_W'(adc_data);
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_QUANT: begin
          acc <= '0;
          cnt <= '0;
          ch  <= ch + 2'd1;
          if (!skip) lvl[ch] <= lvl_new;
          if (ch == CH_LEVEL)
            pub <= {lvl[CH_RAIN], lvl[CH_SEIS], lvl[CH_WIND], skip ? lvl[CH_LEVEL] : lvl_new};
        end
        default: ;
      endcase
    end
  end

`ifdef SENSOR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wdog;
  logic [3:0]      fault;

  // An ack on the expiry cycle wins; only a silent final cycle counts as a timeout.
  assign timeout      = (state == ST_SAMPLE) && !adc_ack && (wdog == WD_W'(TIMEOUT_CYC - 1));
  assign sensor_fault = fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog  <= '0;
      skip  <= 1'b0;
      fault <= '0;
    end else begin
      if (state == ST_SAMPLE) begin
        if (adc_ack) begin
          wdog <= '0;
        end else if (timeout) begin
          wdog      <= '0;
          skip      <= 1'b1;
          fault[ch] <= 1'b1;
        end else begin
          wdog <= wdog + WD_W'(1);
        end
      end else begin
        wdog <= '0;
      end
      if (state == ST_QUANT) begin
        skip <= 1'b0;
        if (!skip) fault[ch] <= 1'b0;
      end
    end
  end
`else
  assign timeout      = 1'b0;
  assign skip         = 1'b0;
  assign sensor_fault = 4'b0;
`endif

endmodule

// File: tb/tb_sensor_level_encoder.sv
// Self-checking bench for sensor_level_encoder: directed scenarios plus randomized scans.
// The timeout scenario is included when SENSOR_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_sensor_level_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       adc_ack = 1'b0;
  logic [7:0] adc_data = 8'd0;
  logic       adc_req;
  logic [1:0] adc_sel;
  logic       r1, r0, s1, s0, w1, w0, l1, l0;
  logic       levels_valid;
  logic       scan_busy;
  logic [3:0] sensor_fault;
  logic [7:0] levels;

  int checks = 0;
  int errors = 0;
  int m_lvl [4];
  int m_fault;
  int samp [4][4];

  assign levels = {r1, r0, s1, s0, w1, w0, l1, l0};

  sensor_level_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .adc_req      (adc_req),
    .adc_sel      (adc_sel),
    .adc_ack      (adc_ack),
    .adc_data     (adc_data),
    .r1           (r1),
    .r0           (r0),
    .s1           (s1),
    .s0           (s0),
    .w1           (w1),
    .w0           (w0),
    .l1           (l1),
    .l0           (l0),
    .levels_valid (levels_valid),
    .scan_busy    (scan_busy),
    .sensor_fault (sensor_fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference hysteresis: count thresholds reached rising and falling, then combine.
  function automatic int refLevel(input int avg, input int cur);
    int th [3];
    int up, down, lo, held;
    th[0] = 64; th[1] = 128; th[2] = 192;
    up = 0;
    down = 0;
    for (int i = 0; i < 3; i++) begin
      lo = th[i] - 8;
      if (lo < 0) lo = 0;
      if (avg >= th[i]) up++;
      if (avg >= lo) down++;
    end
    held = (cur < down) ? cur : down;
    return (up > held) ? up : held;
  endfunction

  function automatic logic [7:0] packLevels();
    return 8'((m_lvl[0] << 6) | (m_lvl[1] << 4) | (m_lvl[2] << 2) | m_lvl[3]);
  endfunction

  task automatic setChannel(input int ch, input int a, input int b, input int c, input int d);
    samp[ch][0] = a; samp[ch][1] = b; samp[ch][2] = c; samp[ch][3] = d;
  endtask

  function automatic int pickValue();
    int edges [14];
    edges = '{0, 55, 56, 63, 64, 119, 120, 127, 128, 183, 184, 191, 192, 255};
    return edges[$urandom_range(0, 13)];
  endfunction

  task automatic randomScanData();
    int v;
    for (int c = 0; c < 4; c++) begin
      if ($urandom_range(0, 1) == 0) begin
        v = pickValue();
        setChannel(c, v, v, v, v);
      end else begin
        setChannel(c, $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 255));
      end
    end
  endtask

  // Runs one scan from the current negedge until the publish cycle, modelling captures.
  task automatic applyStimulus(input int ack_pct, input bit check_lat, input bit drop_en, input int stall_ch);
    int  exp_ch = 0;
    int  cap_idx = 0;
    int  sum = 0;
    int  cyc = 0;
    int  start = -1;
    bit  done = 1'b0;
    bit  req_now;
    bit  ack_now;
    logic [1:0] sel_now;
`ifdef SENSOR_TIMEOUT_EN
    int  wd = 0;
`endif
    while (!done && cyc < 400) begin
      if (drop_en && exp_ch == 1) enable = 1'b0;
      ack_now = (exp_ch == stall_ch) ? 1'b0 : ($urandom_range(0, 99) < ack_pct);
      adc_ack = ack_now;
      if (ack_now && exp_ch < 4) adc_data = 8'(samp[exp_ch][cap_idx]);
      else                       adc_data = 8'($urandom);
      req_now = adc_req;
      sel_now = adc_sel;
      if (req_now && start < 0) start = cyc;
      if (levels_valid) begin
        done = 1'b1;
        checkOutput("scan_complete", exp_ch, 4);
        checkOutput("levels", levels, packLevels());
        checkOutput("fault", sensor_fault, m_fault);
        if (check_lat) checkOutput("latency", cyc - start, 20);
      end
      @(posedge clk);
      if (!done && req_now && exp_ch < 4) begin
        if (ack_now) begin
          checkOutput("adc_sel", sel_now, exp_ch);
          sum += samp[exp_ch][cap_idx];
          cap_idx++;
`ifdef SENSOR_TIMEOUT_EN
          wd = 0;
`endif
          if (cap_idx == 4) begin
            m_lvl[exp_ch] = refLevel(sum / 4, m_lvl[exp_ch]);
            m_fault &= ~(1 << exp_ch);
            exp_ch++;
            cap_idx = 0;
            sum = 0;
          end
        end else begin
`ifdef SENSOR_TIMEOUT_EN
          wd++;
          if (wd == 16) begin
            m_fault |= (1 << exp_ch);
            exp_ch++;
            cap_idx = 0;
            sum = 0;
            wd = 0;
          end
`endif
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!done) checkOutput("publish_wait_expired", 0, 1);
  endtask

  initial begin
    int pulses;
    int busy;
    int held_s;
    for (int c = 0; c < 4; c++) m_lvl[c] = 0;
    m_fault = 0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {adc_req, adc_sel, levels, levels_valid, scan_busy, sensor_fault}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1: reset mid-SAMPLE aborts immediately
    enable = 1'b1;
    adc_ack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("busy_before_reset", {scan_busy, adc_req}, 2'b11);
    #2 rst_n = 1'b0;
    #1 checkOutput("midscan_reset",
                   {adc_req, adc_sel, levels, levels_valid, scan_busy, sensor_fault}, 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    busy = 0;
    repeat (25) begin
      @(negedge clk);
      if (levels_valid) pulses++;
      if (scan_busy || adc_req) busy++;
    end
    checkOutput("no_publish_after_reset", pulses, 0);
    checkOutput("idle_after_reset", busy, 0);

    // Scenario 2: all samples 200, ack held high
    for (int c = 0; c < 4; c++) setChannel(c, 200, 200, 200, 200);
    enable = 1'b1;
    applyStimulus(100, 1'b1, 1'b0, -1);
    checkOutput("all_200", levels, 8'hFF);

    // Scenario 3: rain average 65, others 0
    setChannel(0, 60, 60, 70, 70);
    for (int c = 1; c < 4; c++) setChannel(c, 0, 0, 0, 0);
    applyStimulus(100, 1'b0, 1'b0, -1);
    checkOutput("rain_65", levels, 8'h40);

    // Scenario 4: hysteresis walk on rain
    setChannel(0, 150, 150, 150, 150);
    applyStimulus(100, 1'b0, 1'b0, -1);
    checkOutput("rain_150", {r1, r0}, 2);
    setChannel(0, 124, 124, 124, 124);
    applyStimulus(90, 1'b0, 1'b0, -1);
    checkOutput("rain_124_held", {r1, r0}, 2);
    setChannel(0, 119, 119, 119, 119);
    applyStimulus(90, 1'b0, 1'b0, -1);
    checkOutput("rain_119_drop", {r1, r0}, 1);
    setChannel(0, 192, 192, 192, 192);
    applyStimulus(90, 1'b0, 1'b0, -1);
    checkOutput("rain_192_rise", {r1, r0}, 3);

    // Randomized scans with sporadic ack
    for (int n = 0; n < 12; n++) begin
      randomScanData();
      applyStimulus(70, 1'b0, 1'b0, -1);
    end

    // Scenario 5: enable dropped during channel 1
    randomScanData();
    applyStimulus(80, 1'b0, 1'b1, -1);
    pulses = 0;
    busy = 0;
    repeat (6) begin
      @(negedge clk);
      if (levels_valid) pulses++;
      if (scan_busy || adc_req) busy++;
    end
    checkOutput("no_second_publish", pulses, 0);
    checkOutput("idle_after_drop", busy, 0);

`ifdef SENSOR_TIMEOUT_EN
    // Scenario 6: seismic stalls, faults, then recovers
    enable = 1'b1;
    held_s = m_lvl[1];
    randomScanData();
    applyStimulus(100, 1'b0, 1'b0, 1);
    checkOutput("seis_fault", sensor_fault, 4'b0010);
    checkOutput("seis_held", {s1, s0}, held_s);
    randomScanData();
    applyStimulus(100, 1'b0, 1'b0, -1);
    checkOutput("seis_fault_cleared", sensor_fault, 4'b0000);
`else
    held_s = 0;
    checkOutput("fault_tied_low", sensor_fault, held_s);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
